// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch port.
package imem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_PC_W   = 32;

  // addi x0,x0,0 -- handed back in place of data on any faulting fetch
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  // Why a fetch faulted; only the any-fault bit leaves the block.
  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrMisalign = 2'd1,
    ErrRange    = 2'd2
  } err_cause_e;

  function automatic logic err_flag(input err_cause_e cause);
    return cause != ErrNone;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry in-order response buffer. Push and pop may coincide at any
// occupancy; flush empties it and wins over both.
module imem_rsp_fifo #(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  // Popping an empty buffer is a no-op.
  assign do_pop    = pop & (count_q != 2'd0);
  assign head_data = slot_q[rd_ptr_q];
  assign count     = count_q;

  // Pointer/count update; slot contents cleared on reset so outputs idle at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // At count 2 with a pop, wr_ptr equals rd_ptr: the new entry reuses
      // the slot being retired this edge.
      if (push) begin
        slot_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Clocked instruction memory behind a valid/ready fetch port. A request is
// read into the s1 register at accept and moves into a 2-entry response
// buffer on the following edge. A program port rewrites words at run time.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       DEPTH     = DEF_DEPTH,
  parameter int unsigned       PC_W      = DEF_PC_W,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_INST  = DATA_W'(DEF_NOP_INST),
  localparam int unsigned      IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [PC_W-1:0]   rsp_pc,
  output logic              rsp_err,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_wdata
);

  localparam int unsigned ENTRY_W = DATA_W + PC_W + 1;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [IDX_W-1:0]   req_idx;
  err_cause_e         req_cause;
  logic               accept;
  logic               pop;
  logic [1:0]         buf_count;
  logic [2:0]         occ;

  logic               s1_valid_q;
  logic [DATA_W-1:0]  s1_inst_q;
  logic [PC_W-1:0]    s1_pc_q;
  err_cause_e         s1_cause_q;

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;

  // Array powers up zero-filled.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] = '0;
    end
  end

  // Fault classification of the incoming PC; misalignment reported first.
  always_comb begin
    req_cause = ErrNone;
    if (req_pc[1:0] != 2'b00) begin
      req_cause = ErrMisalign;
    end else if ((req_pc >> 2) >= PC_W'(DEPTH)) begin
      req_cause = ErrRange;
    end
  end

  assign req_idx = req_pc[IDX_W+1:2];

  // Everything in flight (s1 plus buffered) must fit the two buffer slots.
  assign occ       = {1'b0, buf_count} + {2'b00, s1_valid_q};
  assign rsp_valid = (buf_count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = rst_n & ~prog_en & ~flush &
                     ((occ < 3'd2) | ((occ == 3'd2) & pop));
  assign accept    = req_valid & req_ready;

  // Program-port writes; reads in the same edge see the old word.
  always_ff @(posedge clk) begin
    if (prog_en && prog_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  // s1 occupancy: cleared by reset and flush, otherwise follows accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
    end
  end

  // s1 payload; faulting fetches never touch the array and carry the NOP.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pc_q    <= req_pc;
      s1_cause_q <= req_cause;
      s1_inst_q  <= (req_cause == ErrNone) ? mem_q[req_idx] : NOP_INST;
    end
  end

  assign push_data = {s1_inst_q, s1_pc_q, err_flag(s1_cause_q)};

  imem_rsp_fifo #(
    .WIDTH (ENTRY_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (s1_valid_q),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (buf_count)
  );

  assign {rsp_inst, rsp_pc, rsp_err} = head_data;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed scenarios plus a randomized phase, all checked against a
// transaction-level model: an array image and an ordered queue of
// outstanding fetches, each becoming visible one edge after accept.
module tb_imem_fetch_port;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_pc;
  logic        rsp_err;
  logic        prog_en = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [31:0] prog_wdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        pend[$];
  int          vis_n = 0;
  logic [31:0] ref_mem [DEPTH];

  imem_fetch_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_inst   (rsp_inst),
    .rsp_pc     (rsp_pc),
    .rsp_err    (rsp_err),
    .prog_en    (prog_en),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after an edge, check outputs, advance the model.
  task automatic cycle(input logic rn, input logic rv, input logic [31:0] pc,
                       input logic rr, input logic fl, input logic pe, input logic pw,
                       input logic [7:0] pa, input logic [31:0] pd);
    logic exp_valid;
    logic exp_pop;
    logic exp_ready;
    logic acc;
    exp_t e;
    rst_n = rn; req_valid = rv; req_pc = pc; rsp_ready = rr; flush = fl;
    prog_en = pe; prog_we = pw; prog_addr = pa; prog_wdata = pd;
    #1;
    exp_valid = (vis_n > 0);
    exp_pop   = exp_valid && rr;
    exp_ready = rn && !pe && !fl &&
                (pend.size() < 2 || (pend.size() == 2 && exp_pop));
    check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("rsp_inst", rsp_inst, pend[0].inst);
      check("rsp_pc", rsp_pc, pend[0].pc);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, pend[0].err});
    end
    acc    = rv && exp_ready;
    e.pc   = pc;
    e.err  = (pc[1:0] != 2'b00) || ((pc >> 2) >= DEPTH);
    e.inst = e.err ? NOP : ref_mem[pc[9:2]];
    @(posedge clk);
    if (pe && pw) ref_mem[pa] = pd;
    if (!rn || fl) begin
      pend.delete();
      vis_n = 0;
    end else begin
      if (exp_pop) void'(pend.pop_front());
      vis_n = pend.size();
      if (acc) pend.push_back(e);
    end
    #1;
    // Buffered entries are exactly the model's visible ones; also catches overflow.
    check("buf_count", {30'b0, dut.buf_count}, 32'(vis_n));
  endtask

  task automatic req(input logic [31:0] pc, input logic rr);
    cycle(1'b1, 1'b1, pc, rr, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic idle(input logic rr);
    cycle(1'b1, 1'b0, 32'h0, rr, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_inst", rsp_inst, 32'h0);
    check("reset_rsp_pc", rsp_pc, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("reset_req_ready", {31'b0, req_ready}, 32'h0);

    // Load a random program image through the program port
    for (int i = 0; i < int'(DEPTH); i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'(i), $urandom);
    end
    idle(1'b1);

    // 1: back-to-back fetches, one response per cycle
    req(32'h0, 1'b1);
    req(32'h4, 1'b1);
    req(32'h8, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 2: back-pressure fills the buffer, then release
    req(32'h20, 1'b0);
    req(32'h24, 1'b0);
    req(32'h28, 1'b0);
    req(32'h28, 1'b0);
    req(32'h28, 1'b1);
    req(32'h2c, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // 3: misaligned, out of range, then a normal fetch
    req(32'h2, 1'b1);
    req(32'(DEPTH * 4), 1'b1);
    req(32'h10, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // 4: flush drops two outstanding fetches
    req(32'h30, 1'b0);
    req(32'h34, 1'b0);
    cycle(1'b1, 1'b1, 32'h38, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    idle(1'b1);
    req(32'h40, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 5: write index 5 while a fetch of it sits in s1
    req(32'h14, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 32'hDEAD_BEEF);
    idle(1'b1);
    req(32'h14, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 6: reset with the buffer full
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    cycle(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    check("post_reset_rsp_inst", rsp_inst, 32'h0);
    req(32'h0, 1'b1);
    req(32'h14, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      int          r;
      logic [31:0] pc;
      logic        pe;
      r  = int'($urandom_range(0, 99));
      pc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      if (r < 5) begin
        pc = $urandom;
      end else if (r < 10) begin
        pc[1:0] = 2'($urandom_range(1, 3));
      end else if (r < 14) begin
        pc = 32'(DEPTH * 4) + {28'b0, 2'($urandom_range(0, 3)), 2'b00};
      end
      pe = ($urandom_range(0, 11) == 0);
      cycle($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0, pc,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
            pe, pe && ($urandom_range(0, 1) == 1), 8'($urandom), $urandom);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
